// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if -- serial slot bus between a TDM source and the 4-way
// demultiplexer. The producer side drives the slot strobe, frame marker,
// serial data and the error-clear request. The demultiplexer side returns
// the slot pointer, the demultiplexed word and the status flags.
// Signal names match the demultiplexer's documented port names.

interface tdm_demux4_if;

    logic       en;
    logic       frame_sync;
    logic       din;
    logic       err_clr;
    logic [2:0] select;
    logic [3:0] D;
    logic       frame_valid;
    logic       sync_err;
    logic       parity_err;

    // Producer / testbench side
    modport master (
        output en,
        output frame_sync,
        output din,
        output err_clr,
        input  select,
        input  D,
        input  frame_valid,
        input  sync_err,
        input  parity_err
    );

    // Demultiplexer side
    modport slave (
        input  en,
        input  frame_sync,
        input  din,
        input  err_clr,
        output select,
        output D,
        output frame_valid,
        output sync_err,
        output parity_err
    );

endinterface : tdm_demux4_if

// File: rtl/tdm_demux4.sv
// tdm_demux4 -- serial time-division demultiplexer, 4 data slots per frame.
//
// A HUNT/RUN FSM waits for frame_sync, then collects one bit per en cycle
// into a shadow register. When the last slot arrives, the completed word is
// loaded into D and frame_valid pulses for one cycle. After lock, missing
// frame_sync pulses are tolerated, so the block flywheels across them. A
// frame_sync that arrives mid-frame raises sticky sync_err and restarts the
// frame at slot 0.
//
// Optional feature, enabled by defining the macro DEMUX_PARITY_EN:
//   * Each frame gets a fifth slot that carries even parity over slots 0-3.
//   * D and frame_valid update on that fifth slot.
//   * A parity mismatch raises sticky parity_err.
// With the macro undefined, frames are 4 slots long and parity_err is 0.

module tdm_demux4 #(
    parameter logic [3:0] D_RESET = 4'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux4_if.slave   bus
);

`ifdef DEMUX_PARITY_EN
    // Slots 0-3 are held in the shadow register; slot 4 carries parity.
    localparam logic [2:0] LAST_SLOT = 3'd4;
    localparam int         SHADOW_W  = 4;
`else
    // Slot 3 goes straight from din into D, so only slots 0-2 are held.
    localparam logic [2:0] LAST_SLOT = 3'd3;
    localparam int         SHADOW_W  = 3;
`endif

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          select_q, select_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic [3:0]          d_q, d_d;
    logic                frame_valid_q, frame_valid_d;
    logic                sync_err_q, sync_err_d;
`ifdef DEMUX_PARITY_EN
    logic                parity_err_q, parity_err_d;
`endif

    // Decoded slot events for the current cycle
    logic start_s;       // HUNT: first sync found, this slot is slot 0
    logic early_sync_s;  // RUN: sync arrived before the frame completed
    logic capture_s;     // RUN: ordinary in-frame slot
    logic frame_done_s;  // RUN: the last slot of the frame is being taken

    // Returns cur with bit idx replaced by bit_v. An idx outside the shadow
    // range leaves cur unchanged.
    function automatic logic [SHADOW_W-1:0] shadow_write(
        input logic [SHADOW_W-1:0] cur,
        input logic [2:0]          idx,
        input logic                bit_v
    );
        logic [SHADOW_W-1:0] res;
        res = cur;
        for (int i = 0; i < SHADOW_W; i++) begin
            if (idx == 3'(i)) begin
                res[i] = bit_v;
            end else begin
                res[i] = cur[i];
            end
        end
        return res;
    endfunction

`ifdef DEMUX_PARITY_EN
    // Even-parity bit that makes the 5-bit frame contain an even count of 1s
    function automatic logic even_parity4(input logic [3:0] data);
        return ^data;
    endfunction
`endif

    // Classify the current cycle's slot strobe
    always_comb begin
        start_s      = 1'b0;
        early_sync_s = 1'b0;
        capture_s    = 1'b0;
        frame_done_s = 1'b0;
        if (bus.en == 1'b1) begin
            if (state_q == ST_HUNT) begin
                start_s = bus.frame_sync;
            end else if (bus.frame_sync == 1'b1 && select_q != 3'd0) begin
                early_sync_s = 1'b1;
            end else begin
                capture_s    = 1'b1;
                frame_done_s = (select_q == LAST_SLOT);
            end
        end else begin
            start_s      = 1'b0;
            early_sync_s = 1'b0;
            capture_s    = 1'b0;
            frame_done_s = 1'b0;
        end
    end

    // FSM next state: leave HUNT on the first sync; RUN holds until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT: begin
                if (start_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // Slot pointer: restart after a sync, wrap at frame end, else advance
    always_comb begin
        select_d = select_q;
        if (start_s || early_sync_s) begin
            select_d = 3'd1;
        end else if (frame_done_s) begin
            select_d = 3'd0;
        end else if (capture_s) begin
            select_d = select_q + 3'd1;
        end else begin
            select_d = select_q;
        end
    end

    // Shadow capture: a sync drops the partial frame and keeps din as slot 0
    always_comb begin
        shadow_d = shadow_q;
        if (start_s || early_sync_s) begin
            shadow_d    = '0;
            shadow_d[0] = bus.din;
        end else if (capture_s && !frame_done_s) begin
            shadow_d = shadow_write(shadow_q, select_q, bus.din);
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Output word and one-cycle valid pulse on frame completion
    always_comb begin
        d_d           = d_q;
        frame_valid_d = 1'b0;
        if (frame_done_s) begin
`ifdef DEMUX_PARITY_EN
            d_d = shadow_q;
`else
            d_d = {bus.din, shadow_q};
`endif
            frame_valid_d = 1'b1;
        end else begin
            d_d           = d_q;
            frame_valid_d = 1'b0;
        end
    end

    // Sticky error flags; a new error event wins over err_clr
    always_comb begin
        sync_err_d = sync_err_q;
        if (early_sync_s) begin
            sync_err_d = 1'b1;
        end else if (bus.err_clr) begin
            sync_err_d = 1'b0;
        end else begin
            sync_err_d = sync_err_q;
        end
`ifdef DEMUX_PARITY_EN
        parity_err_d = parity_err_q;
        if (frame_done_s && (even_parity4(shadow_q) != bus.din)) begin
            parity_err_d = 1'b1;
        end else if (bus.err_clr) begin
            parity_err_d = 1'b0;
        end else begin
            parity_err_d = parity_err_q;
        end
`endif
    end

    // State registers; reset discards any partial frame and re-enters HUNT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            select_q      <= 3'd0;
            shadow_q      <= '0;
            d_q           <= D_RESET;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef DEMUX_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            select_q      <= select_d;
            shadow_q      <= shadow_d;
            d_q           <= d_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
`ifdef DEMUX_PARITY_EN
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign bus.select      = select_q;
    assign bus.D           = d_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_err    = sync_err_q;
`ifdef DEMUX_PARITY_EN
    assign bus.parity_err  = parity_err_q;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule : tdm_demux4
